regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised multi-port integer register file for the pipelined ARMv8 core; generation after the single-write, two-read file.
- Adds configurable read/write port counts, a hardwired XZR (X31), write-to-read bypass, and a per-register pending-write scoreboard.
- Sits between decode (reads, issue marking) and writeback (writes, pending clear). Drives the load-use/structural stall logic.

Parameters:
- DATA_W, 64, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- NUM_RD, 3, number of read ports (3 covers STR reg-offset).
- NUM_WR, 2, number of write ports (ALU and load writeback).
- ZERO_REG, 1: when 1, index 2**ADDR_W-1 reads as 0, ignores writes, is never pending.
- BYPASS, 1: when 1, a same-cycle write is forwarded to the read data.

Ports:
- clock  in  1  core clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read indices; port p occupies bits [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, combinational from rd_addr and state.
- rd_pending  out  NUM_RD  1 = the register has an outstanding producer; consumer must stall.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  write indices.
- wr_data  in  NUM_WR*DATA_W  write data.
- issue_en  in  1  marks issue_addr pending (producer issued).
- issue_addr  in  ADDR_W  destination of the issuing instruction.
- pending_any  out  1  OR of all pending bits; used for drain/flush.

Behaviour:
- Storage: 2**ADDR_W x DATA_W flops plus a 2**ADDR_W-bit pending vector.
- Reset: on a rising edge with reset=1, all registers are cleared to 0 and all pending bits to 0. Writes and issue in that cycle are ignored.
- Outputs while reset=1: rd_data reflects the pre-edge state. After the edge, all rd_data=0, rd_pending=0, pending_any=0.
- Write: on the edge, each enabled port w writes wr_data[w] to regfile[wr_addr[w]].
- Write collision: if several ports target the same index, the highest-numbered port wins.
- Pending clear: an enabled write clears the pending bit of its index.
- Issue: issue_en=1 sets pending[issue_addr] on the edge.
- Issue and write on the same index in the same cycle: pending ends set (the new producer wins); the data write still occurs.
- Read, latency 0 (combinational), BYPASS=0: rd_data = regfile[addr].
- Read, BYPASS=1: if any enabled write port targets the same index this cycle, rd_data = that port's wr_data, highest-numbered port first.
- rd_pending, BYPASS=0: pending[addr].
- rd_pending, BYPASS=1: pending[addr] AND NOT (a same-cycle write to addr). Same-cycle issue does not affect rd_pending until the next cycle.
- ZERO_REG=1 and addr = all-ones: rd_data=0, rd_pending=0, no bypass. Writes to that index are dropped. Issue to that index is ignored.
- ZERO_REG=0: the all-ones index behaves as an ordinary register.
- pending_any = OR of the pending vector. It is registered-state-derived, so bypass does not affect it.
- X/unknown addresses never occur on enabled ports. Disabled-port address and data values are don't-care and must not affect state or outputs.

Decomposition:
- Shared package core_rf_pkg: REG_ADDR_W=5, XLEN=64, XZR_IDX=31, default NUM_RD/NUM_WR constants, typedef for a register index.
- One natural sub-module, rf_read_port, instantiated NUM_RD times. It implements the storage select, bypass priority mux, zero-register override and rd_pending qualification for a single read port.

Test Plan:
- Reset, then read all 32 indices on port 0 -> rd_data=0, rd_pending=0, pending_any=0.
- Write X5=0xDEADBEEF_00000001 via port 0; next cycle read X5 on all ports -> 0xDEADBEEF_00000001. Write X31=0xFF -> X31 reads 0.
- Same cycle: port 0 writes X7=0x11, port 1 writes X7=0x22 -> X7 reads 0x22 next cycle. With BYPASS=1, the same-cycle read of X7 also returns 0x22.
- issue_en X3; next cycle rd_pending for X3=1 and pending_any=1. Write X3=0x33 -> same-cycle rd_pending=0 and rd_data=0x33 (BYPASS=1); next cycle pending_any=0.
- Issue X4 and write X4=0x44 in the same cycle -> next cycle X4 reads 0x44 with rd_pending=1.
- Load X1..X4 and mark X9 pending, then assert reset for 1 cycle while port 0 writes X2=0x99 -> all registers read 0, no pending bits set, write dropped.

Source files
------------

// File: rtl/core_rf_pkg.sv
// Shared constants and types for the integer register file of the pipelined ARMv8 core.
package core_rf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 64;
    localparam int XZR_IDX    = 31;
    localparam int NUM_RD_DEF = 3;
    localparam int NUM_WR_DEF = 2;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bus of the register file: read ports, write ports, issue marking.
interface regfile_scoreboard_if
    import core_rf_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pending;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;
    logic                     pending_any;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        input  rd_data, rd_pending, pending_any
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        output rd_data, rd_pending, pending_any
    );
endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: storage select, write bypass, zero-register override, pending qualification.
module rf_read_port
    import core_rf_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_WR   = NUM_WR_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        regs [2**ADDR_W],
    input  logic [2**ADDR_W-1:0]     pending,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0]        data,
    output logic                     busy
);
    logic hit;

    always_comb begin
        data = regs[addr];
        hit  = 1'b0;
        if (BYPASS != 0) begin
            // Ascending scan so the highest-numbered matching port is the one left in data.
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == addr) begin
                    hit  = 1'b1;
                    data = wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
        busy = pending[addr] && !hit;
        if (ZERO_REG != 0 && addr == '1) begin
            data = '0;
            busy = 1'b0;
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with hardwired XZR, write bypass and a per-register pending scoreboard.
module regfile_scoreboard
    import core_rf_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int NUM_WR   = NUM_WR_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic                 clock,
    input logic                 reset,
    regfile_scoreboard_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DATA_W-1:0] rd_data_p [NUM_RD];
    logic              rd_busy_p [NUM_RD];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.wr_en[w] &&
                    !(ZERO_REG != 0 && bus.wr_addr[w*ADDR_W +: ADDR_W] == '1)) begin
                    regs[bus.wr_addr[w*ADDR_W +: ADDR_W]]    <= bus.wr_data[w*DATA_W +: DATA_W];
                    pending[bus.wr_addr[w*ADDR_W +: ADDR_W]] <= 1'b0;
                end
            end
            // Issued after the write clears so a new producer on the same index keeps it pending.
            if (bus.issue_en && !(ZERO_REG != 0 && bus.issue_addr == '1)) begin
                pending[bus.issue_addr] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .addr    (bus.rd_addr[p*ADDR_W +: ADDR_W]),
            .regs    (regs),
            .pending (pending),
            .wr_en   (bus.wr_en),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .data    (rd_data_p[p]),
            .busy    (rd_busy_p[p])
        );
    end

    always_comb begin
        bus.rd_data    = '0;
        bus.rd_pending = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            bus.rd_data[p*DATA_W +: DATA_W] = rd_data_p[p];
            bus.rd_pending[p]               = rd_busy_p[p];
        end
    end

    assign bus.pending_any = |pending;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with default parameters (64-bit, 32 regs, 3 read, 2 write, XZR, bypass).
module tb_regfile_scoreboard;
    import core_rf_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    regfile_scoreboard_if bus ();

    regfile_scoreboard dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.wr_en      = '0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.issue_en   = 1'b0;
        bus.issue_addr = '0;
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        bus.rd_addr[p*5 +: 5] = a;
    endtask

    task automatic set_wr(input int w, input logic [4:0] a, input logic [63:0] d);
        bus.wr_en[w]           = 1'b1;
        bus.wr_addr[w*5 +: 5]  = a;
        bus.wr_data[w*64 +: 64] = d;
    endtask

    function automatic logic [63:0] rdd(input int p);
        return bus.rd_data[p*64 +: 64];
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.rd_addr = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state across all indices.
        for (int i = 0; i < 32; i++) begin
            set_rd(0, 5'(i));
            #1;
            check($sformatf("rst_data_x%0d", i), rdd(0), 64'h0);
            check($sformatf("rst_pend_x%0d", i), 64'(bus.rd_pending[0]), 64'h0);
        end
        check("rst_pending_any", 64'(bus.pending_any), 64'h0);

        // Basic write then read on every port.
        set_wr(0, 5'd5, 64'hDEADBEEF_00000001);
        tick();
        idle();
        for (int p = 0; p < 3; p++) set_rd(p, 5'd5);
        #1;
        for (int p = 0; p < 3; p++) check($sformatf("x5_port%0d", p), rdd(p), 64'hDEADBEEF_00000001);

        // XZR: write dropped, no bypass.
        set_wr(0, 5'd31, 64'hFF);
        set_rd(1, 5'd31);
        #1;
        check("xzr_same_cycle", rdd(1), 64'h0);
        tick();
        idle();
        #1;
        check("xzr_after_write", rdd(1), 64'h0);

        // Write collision: port 1 wins, bypass too.
        set_wr(0, 5'd7, 64'h11);
        set_wr(1, 5'd7, 64'h22);
        set_rd(0, 5'd7);
        #1;
        check("x7_bypass_collision", rdd(0), 64'h22);
        tick();
        idle();
        #1;
        check("x7_stored_collision", rdd(0), 64'h22);

        // Issue X3; same-cycle issue does not show in rd_pending yet.
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd3;
        set_rd(0, 5'd3);
        #1;
        check("x3_pend_same_issue", 64'(bus.rd_pending[0]), 64'h0);
        tick();
        idle();
        #1;
        check("x3_pend_after_issue", 64'(bus.rd_pending[0]), 64'h1);
        check("any_after_issue", 64'(bus.pending_any), 64'h1);
        set_wr(1, 5'd3, 64'h33);
        #1;
        check("x3_pend_bypassed", 64'(bus.rd_pending[0]), 64'h0);
        check("x3_data_bypassed", rdd(0), 64'h33);
        check("any_not_bypassed", 64'(bus.pending_any), 64'h1);
        tick();
        idle();
        #1;
        check("any_after_clear", 64'(bus.pending_any), 64'h0);
        check("x3_pend_cleared", 64'(bus.rd_pending[0]), 64'h0);
        check("x3_data_stored", rdd(0), 64'h33);

        // Issue and write same index: producer wins.
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd4;
        set_wr(0, 5'd4, 64'h44);
        tick();
        idle();
        set_rd(0, 5'd4);
        #1;
        check("x4_data", rdd(0), 64'h44);
        check("x4_pend", 64'(bus.rd_pending[0]), 64'h1);
        check("x4_any", 64'(bus.pending_any), 64'h1);

        // Disabled port values are ignored.
        bus.wr_addr = {5'd5, 5'd5};
        bus.wr_data = {64'hBAD0BAD0_BAD0BAD0, 64'hBAD1BAD1_BAD1BAD1};
        set_rd(2, 5'd5);
        #1;
        check("disabled_no_bypass", rdd(2), 64'hDEADBEEF_00000001);
        tick();
        idle();
        #1;
        check("disabled_no_write", rdd(2), 64'hDEADBEEF_00000001);

        // Clear X4, then issue to XZR must not set anything.
        set_wr(1, 5'd4, 64'h45);
        tick();
        idle();
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd31;
        tick();
        idle();
        set_rd(0, 5'd31);
        #1;
        check("xzr_issue_any", 64'(bus.pending_any), 64'h0);
        check("xzr_issue_pend", 64'(bus.rd_pending[0]), 64'h0);

        // Load X1..X4, mark X9, then reset while writing X2.
        set_wr(0, 5'd1, 64'h101);
        set_wr(1, 5'd2, 64'h102);
        tick();
        idle();
        set_wr(0, 5'd3, 64'h103);
        set_wr(1, 5'd4, 64'h104);
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd9;
        tick();
        idle();
        check("pre_reset_any", 64'(bus.pending_any), 64'h1);
        reset = 1'b1;
        set_wr(0, 5'd2, 64'h99);
        set_rd(1, 5'd1);
        set_rd(2, 5'd4);
        #1;
        check("in_reset_x1", rdd(1), 64'h101);
        check("in_reset_x4", rdd(2), 64'h104);
        tick();
        reset = 1'b0;
        idle();
        #1;
        for (int r = 1; r <= 4; r++) begin
            set_rd(0, 5'(r));
            #1;
            check($sformatf("post_reset_x%0d", r), rdd(0), 64'h0);
        end
        set_rd(0, 5'd9);
        #1;
        check("post_reset_x9_pend", 64'(bus.rd_pending[0]), 64'h0);
        check("post_reset_any", 64'(bus.pending_any), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
